// File: rtl/mips_core_pkg.sv
// Shared core definitions: active-list sizing defaults and the entry record layout.
package mips_core_pkg;

  localparam int AL_DEPTH  = 32;
  localparam int AL_PHYS_W = 6;
  localparam int AL_LOG_W  = 5;

  // One in-flight instruction: bookkeeping bits plus the mapping it displaced.
  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 uses_rw;
    logic [AL_LOG_W-1:0]  logical;
    logic [AL_PHYS_W-1:0] physical;
  } active_list_entry_t;

endpackage

// File: rtl/active_list.sv
// Active list: in-order circular buffer of renamed instructions. Entries are
// allocated at the tail, marked done out of order, and retired in order at the
// head, returning the displaced physical register to the free list.
module active_list
  import mips_core_pkg::*;
#(
  parameter int DEPTH  = AL_DEPTH,
  parameter int PHYS_W = AL_PHYS_W,
  parameter int LOG_W  = AL_LOG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic                     alloc_uses_rw,
  input  logic [LOG_W-1:0]         alloc_prev_logical,
  input  logic [PHYS_W-1:0]        alloc_prev_physical,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     done_valid,
  input  logic [$clog2(DEPTH)-1:0] done_tag,
  output logic                     commit_valid,
  output logic [LOG_W-1:0]         commit_logical,
  output logic                     free_valid,
  output logic [PHYS_W-1:0]        free_physical,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]        head_q, head_d;
  logic [AW:0]        tail_q, tail_d;
  active_list_entry_t entries_q [DEPTH];
  active_list_entry_t entries_d [DEPTH];

  logic [AW-1:0]      head_idx_s;
  logic [AW-1:0]      tail_idx_s;
  logic               full_s;
  logic               alloc_fire_s;
  active_list_entry_t head_entry_s;

  assign head_idx_s   = head_q[AW-1:0];
  assign tail_idx_s   = tail_q[AW-1:0];
  assign full_s       = (head_q[AW] != tail_q[AW]) && (head_idx_s == tail_idx_s);
  assign head_entry_s = entries_q[head_idx_s];

  assign count        = tail_q - head_q;
  assign alloc_ready  = !full_s && !flush;
  assign alloc_fire_s = alloc_valid && alloc_ready;
  assign alloc_tag    = tail_idx_s;

  // Retirement and free-list return decisions for the current head entry.
  always_comb begin
    commit_valid   = 1'b0;
    free_valid     = 1'b0;
    commit_logical = '0;
    free_physical  = '0;
    if (head_entry_s.valid && head_entry_s.done && !flush) begin
      commit_valid   = 1'b1;
      commit_logical = head_entry_s.logical;
      if (head_entry_s.uses_rw) begin
        free_valid    = 1'b1;
        free_physical = head_entry_s.physical;
      end else begin
        free_valid    = 1'b0;
        free_physical = '0;
      end
    end else begin
      commit_valid   = 1'b0;
      commit_logical = '0;
    end
  end

  // Next-state for pointers and entries; flush overrides every other update.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      // A completion for an entry that is not in flight is stale and dropped.
      if (done_valid && entries_q[done_tag].valid) begin
        entries_d[done_tag].done = 1'b1;
      end else begin
        entries_d[done_tag].done = entries_q[done_tag].done;
      end
      // The tail slot is never valid when an allocation fires, so no done
      // update above can collide with this write.
      if (alloc_fire_s) begin
        entries_d[tail_idx_s].valid    = 1'b1;
        entries_d[tail_idx_s].done     = 1'b0;
        entries_d[tail_idx_s].uses_rw  = alloc_uses_rw;
        entries_d[tail_idx_s].logical  = alloc_prev_logical;
        entries_d[tail_idx_s].physical = alloc_prev_physical;
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (commit_valid) begin
        entries_d[head_idx_s].valid = 1'b0;
        entries_d[head_idx_s].done  = 1'b0;
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_active_list.sv
// Self-checking bench for active_list: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_active_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_valid;
  logic       alloc_ready;
  logic       alloc_uses_rw;
  logic [4:0] alloc_prev_logical;
  logic [5:0] alloc_prev_physical;
  logic [4:0] alloc_tag;
  logic       done_valid;
  logic [4:0] done_tag;
  logic       commit_valid;
  logic [4:0] commit_logical;
  logic       free_valid;
  logic [5:0] free_physical;
  logic       flush;
  logic [5:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int tag;
    bit rw;
    int lg;
    int ph;
    bit done;
  } ref_ent_t;

  ref_ent_t ref_q[$];
  int       ref_next_tag;

  active_list dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_uses_rw       (alloc_uses_rw),
    .alloc_prev_logical  (alloc_prev_logical),
    .alloc_prev_physical (alloc_prev_physical),
    .alloc_tag           (alloc_tag),
    .done_valid          (done_valid),
    .done_tag            (done_tag),
    .commit_valid        (commit_valid),
    .commit_logical      (commit_logical),
    .free_valid          (free_valid),
    .free_physical       (free_physical),
    .flush               (flush),
    .count               (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_uses_rw = 1'b0; alloc_prev_logical = 5'd0;
    alloc_prev_physical = 6'd0; done_valid = 1'b0; done_tag = 5'd0; flush = 1'b0;
  endtask

  task automatic set_alloc(input bit rw, input int lg, input int ph);
    alloc_valid = 1'b1; alloc_uses_rw = rw;
    alloc_prev_logical = lg[4:0]; alloc_prev_physical = ph[5:0];
  endtask

  task automatic set_done(input int tag);
    done_valid = 1'b1; done_tag = tag[4:0];
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", alloc_ready); end
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit: got %0b expected 0", commit_valid); end
    checks++; if (free_valid !== 1'b0) begin errors++; $display("FAIL reset_free: got %0b expected 0", free_valid); end
    checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", alloc_tag); end
    checks++; if (free_physical !== 6'd0 || commit_logical !== 5'd0) begin errors++; $display("FAIL reset_data: got phys=%0d log=%0d expected 0/0", free_physical, commit_logical); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    // Reset in the middle of operation discards entries.
    set_alloc(1'b1, 4, 9); tick(); set_alloc(1'b1, 5, 10); tick(); idle();
    set_done(0); tick(); idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (count !== 6'd0 || commit_valid !== 1'b0 || free_valid !== 1'b0) begin errors++; $display("FAIL reset_midop: got count=%0d commit=%0b free=%0b expected 0/0/0", count, commit_valid, free_valid); end
    tick(); #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_midop_late: got %0b expected 0", commit_valid); end
  endtask

  task automatic test_single();
    apply_reset();
    set_alloc(1'b1, 3, 3); #1;
    checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL single_tag: got %0d expected 0", alloc_tag); end
    tick(); idle(); #1;
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
    set_done(0); #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %0b expected 0", commit_valid); end
    tick(); idle(); #1;
    checks++; if (commit_valid !== 1'b1 || free_valid !== 1'b1) begin errors++; $display("FAIL single_commit: got commit=%0b free=%0b expected 1/1", commit_valid, free_valid); end
    checks++; if (free_physical !== 6'd3 || commit_logical !== 5'd3) begin errors++; $display("FAIL single_data: got phys=%0d log=%0d expected 3/3", free_physical, commit_logical); end
    tick(); #1;
    checks++; if (count !== 6'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL single_after: got count=%0d commit=%0b expected 0/0", count, commit_valid); end
  endtask

  task automatic test_out_of_order_done();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 10 + i, 20 + i); #1;
      checks++; if (alloc_tag !== 5'(i)) begin errors++; $display("FAIL ooo_tag: got %0d expected %0d", alloc_tag, i); end
      tick();
    end
    idle();
    for (int t = 2; t >= 0; t--) begin
      set_done(t); #1;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL ooo_early: got %0b expected 0 (done %0d)", commit_valid, t); end
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_logical !== 5'(10 + i) || free_physical !== 6'(20 + i)) begin
        errors++; $display("FAIL ooo_commit: got v=%0b log=%0d phys=%0d expected 1/%0d/%0d", commit_valid, commit_logical, free_physical, 10 + i, 20 + i);
      end
      tick();
    end
    #1;
    checks++; if (commit_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL ooo_drain: got commit=%0b count=%0d expected 0/0", commit_valid, count); end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      set_alloc(1'b1, i, i + 1); #1;
      checks++; if (alloc_tag !== 5'(i) || alloc_ready !== 1'b1) begin errors++; $display("FAIL full_fill: got tag=%0d ready=%0b expected %0d/1", alloc_tag, alloc_ready, i); end
      tick();
    end
    idle(); #1;
    checks++; if (count !== 6'd32 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_state: got count=%0d ready=%0b expected 32/0", count, alloc_ready); end
    set_alloc(1'b1, 7, 7); tick(); idle(); #1;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_extra: got %0d expected 32", count); end
    set_done(0); tick(); idle(); #1;
    checks++; if (commit_valid !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_commit: got commit=%0b ready=%0b expected 1/0", commit_valid, alloc_ready); end
    tick(); #1;
    checks++; if (count !== 6'd31 || alloc_ready !== 1'b1) begin errors++; $display("FAIL full_after: got count=%0d ready=%0b expected 31/1", count, alloc_ready); end
    set_alloc(1'b1, 1, 1); #1;
    checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL full_wrap: got %0d expected 0", alloc_tag); end
    tick(); idle(); #1;
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_refill: got %0d expected 32", count); end
  endtask

  task automatic test_no_rw();
    apply_reset();
    set_alloc(1'b0, 7, 9); tick(); idle();
    set_done(0); tick(); idle(); #1;
    checks++; if (commit_valid !== 1'b1 || free_valid !== 1'b0) begin errors++; $display("FAIL norw_flags: got commit=%0b free=%0b expected 1/0", commit_valid, free_valid); end
    checks++; if (free_physical !== 6'd0 || commit_logical !== 5'd7) begin errors++; $display("FAIL norw_data: got phys=%0d log=%0d expected 0/7", free_physical, commit_logical); end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 5; i++) begin set_alloc(1'b1, i, 30 + i); tick(); end
    idle();
    set_done(0); tick(); idle(); #1;
    checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %0b expected 1", commit_valid); end
    flush = 1'b1; set_alloc(1'b1, 2, 2); #1;
    checks++; if (commit_valid !== 1'b0 || free_valid !== 1'b0 || alloc_ready !== 1'b0) begin errors++; $display("FAIL flush_same: got commit=%0b free=%0b ready=%0b expected 0/0/0", commit_valid, free_valid, alloc_ready); end
    tick(); idle(); #1;
    checks++; if (count !== 6'd0 || alloc_tag !== 5'd0) begin errors++; $display("FAIL flush_next: got count=%0d tag=%0d expected 0/0", count, alloc_tag); end
    set_done(2); tick(); idle(); set_alloc(1'b1, 6, 6); tick(); idle(); set_done(3); tick(); idle(); #1;
    checks++; if (commit_valid !== 1'b0 || count !== 6'd1) begin errors++; $display("FAIL flush_stale: got commit=%0b count=%0d expected 0/1", commit_valid, count); end
    tick(); #1;
    checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_late: got %0b expected 0", commit_valid); end
  endtask

  task automatic test_random();
    int  sz, didx;
    bit  fl, av, dv, rw, exp_ready, exp_commit, exp_free;
    int  lg, ph, dt, exp_log, exp_phys;
    apply_reset();
    ref_q.delete();
    ref_next_tag = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fl = ($urandom_range(39, 0) == 0);
      av = ($urandom_range(99, 0) < 55);
      rw = $urandom_range(1, 0);
      lg = $urandom_range(31, 0);
      ph = $urandom_range(63, 0);
      dv = ($urandom_range(99, 0) < 70);
      if (ref_q.size() > 0 && $urandom_range(9, 0) < 8) begin
        didx = $urandom_range(ref_q.size() - 1, 0);
        dt = ref_q[didx].tag;
      end else begin
        dt = $urandom_range(31, 0);
      end
      alloc_valid = av; alloc_uses_rw = rw; alloc_prev_logical = lg[4:0]; alloc_prev_physical = ph[5:0];
      done_valid = dv; done_tag = dt[4:0]; flush = fl;
      sz = ref_q.size();
      exp_ready  = (sz < 32) && !fl;
      exp_commit = (sz > 0) && ref_q[0].done && !fl;
      exp_free   = exp_commit && ref_q[0].rw;
      exp_log    = exp_commit ? ref_q[0].lg : 0;
      exp_phys   = exp_free ? ref_q[0].ph : 0;
      #1;
      checks++; if (count !== 6'(sz)) begin errors++; $display("FAIL rand_count: cyc %0d got %0d expected %0d", cyc, count, sz); end
      checks++; if (alloc_ready !== exp_ready || alloc_tag !== 5'(ref_next_tag)) begin errors++; $display("FAIL rand_alloc: cyc %0d got ready=%0b tag=%0d expected %0b/%0d", cyc, alloc_ready, alloc_tag, exp_ready, ref_next_tag); end
      checks++; if (commit_valid !== exp_commit || commit_logical !== 5'(exp_log)) begin errors++; $display("FAIL rand_commit: cyc %0d got v=%0b log=%0d expected %0b/%0d", cyc, commit_valid, commit_logical, exp_commit, exp_log); end
      checks++; if (free_valid !== exp_free || free_physical !== 6'(exp_phys)) begin errors++; $display("FAIL rand_free: cyc %0d got v=%0b phys=%0d expected %0b/%0d", cyc, free_valid, free_physical, exp_free, exp_phys); end
      tick();
      if (fl) begin
        ref_q.delete();
        ref_next_tag = 0;
      end else begin
        if (dv) begin
          foreach (ref_q[k]) if (ref_q[k].tag == dt) ref_q[k].done = 1'b1;
        end
        if (exp_commit) void'(ref_q.pop_front());
        if (av && exp_ready) begin
          ref_q.push_back('{tag: ref_next_tag, rw: rw, lg: lg, ph: ph, done: 1'b0});
          ref_next_tag = (ref_next_tag + 1) % 32;
        end
      end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_single();
    test_out_of_order_done();
    test_full_wrap();
    test_no_rw();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
